// File: rtl/odt_console_peer_pkg.sv
// odt_pkg: shared UART timing helpers, frame constants and the FSM state type
package odt_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int UART_BITS = 8;
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
  function automatic int calc_half(input int div);
    return div / 2;
  endfunction
endpackage

// File: rtl/odt_console_peer_sync_fifo.sv
// sync_fifo: power-of-two FIFO with extra-MSB pointers and a combinational head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_push, w_pop;
  assign empty = r_wp == r_rp;
  assign full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout = r_mem[r_rp[AW-1:0]];
  // Storage is not reset; emptiness is defined purely by the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
  end
  // Pointers wrap naturally; the extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/odt_console_peer.sv
// odt_console_peer: console ODT peer bridging XBUF/RBUF 4-phase handshakes to an 8N1 UART
module odt_console_peer
  import odt_pkg::*;
#(
  parameter int CLK_HZ     = 18000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       xmt_stb,
  input  logic [7:0] xmt_data,
  output logic       xmt_rdy,
  output logic       rcv_rdy,
  output logic [7:0] rcv_data,
  input  logic       rcv_stb,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       rx_overrun
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(calc_half(DIV));
  localparam logic [2:0] C_BIT_LAST = 3'(UART_BITS - 1);
  logic [2:0] r_xs, r_rs;
  logic [1:0] r_rx;
  logic r_xmt_rdy, r_rcv_rdy, r_hold, r_overrun, r_uart_tx, r_rx_wait;
  logic [7:0] r_rcv_data, r_tx_sh, r_rx_sh;
  uart_state_t r_tx_st, r_rx_st;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic [2:0] r_tx_bit, r_rx_bit;
  logic w_xs_rise, w_rs_rise, w_line, w_tx_last, w_rx_tick;
  logic w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0] w_tx_dout, w_rx_dout;
  assign w_xs_rise = r_xs[1] & ~r_xs[2];
  assign w_rs_rise = r_rs[1] & ~r_rs[2];
  assign w_line = r_rx[1];
  assign w_tx_push = w_xs_rise;
  assign w_tx_last = r_tx_cnt == C_LAST;
  assign w_tx_pop = !w_tx_empty && (r_tx_st == IDLE || (r_tx_st == STOP && w_tx_last));
  assign w_rx_tick = (r_rx_st == START) ? (r_rx_cnt == C_HALF) : (r_rx_cnt == C_LAST);
  assign w_rx_push = r_rx_st == STOP && w_rx_tick && w_line;
  assign w_rx_pop = w_rs_rise & ~w_rx_empty;
  assign xmt_rdy = r_xmt_rdy;
  assign rcv_rdy = r_rcv_rdy;
  assign rcv_data = r_rcv_data;
  assign uart_tx = r_uart_tx;
  assign rx_overrun = r_overrun;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rstb(rstb), .push(w_tx_push), .pop(w_tx_pop), .din(xmt_data),
    .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rstb(rstb), .push(w_rx_push), .pop(w_rx_pop), .din(r_rx_sh),
    .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
  );
  // Two-flop synchronisers; the strobes get a third flop for edge detection
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_xs <= '0;
      r_rs <= '0;
      r_rx <= 2'b11;
    end else begin
      r_xs <= {r_xs[1:0], xmt_stb};
      r_rs <= {r_rs[1:0], rcv_stb};
      r_rx <= {r_rx[0], uart_rx};
    end
  end
  // Bus-side handshakes: ready flags, registered RX head, pop-hold and sticky overrun
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_xmt_rdy <= 1'b0;
      r_rcv_rdy <= 1'b0;
      r_rcv_data <= '0;
      r_hold <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_xmt_rdy <= ~r_xs[1] & ~w_tx_full;
      r_rcv_rdy <= ~w_rx_empty & ~r_rs[1] & ~r_hold;
      r_hold <= w_rx_pop | (r_hold & r_rs[1]);
      if (!w_rx_empty) r_rcv_data <= w_rx_dout;
      if (w_rx_push && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
    end
  end
  // TX serialiser: each state lasts DIV clocks, STOP chains straight into the next START
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_tx_st <= IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh <= '0;
      r_uart_tx <= 1'b1;
    end else begin
      r_tx_cnt <= (r_tx_st == IDLE || w_tx_last) ? '0 : r_tx_cnt + CW'(1);
      case (r_tx_st)
        IDLE: if (!w_tx_empty) begin
          r_tx_st <= START;
          r_tx_sh <= w_tx_dout;
          r_uart_tx <= 1'b0;
        end
        START: if (w_tx_last) begin
          r_tx_st <= DATA;
          r_tx_bit <= '0;
          r_uart_tx <= r_tx_sh[0];
        end
        DATA: if (w_tx_last) begin
          if (r_tx_bit == C_BIT_LAST) begin
            r_tx_st <= STOP;
            r_uart_tx <= 1'b1;
          end else begin
            r_tx_bit <= r_tx_bit + 3'd1;
            r_tx_sh <= {1'b0, r_tx_sh[7:1]};
            r_uart_tx <= r_tx_sh[1];
          end
        end
        STOP: if (w_tx_last) begin
          r_tx_st <= w_tx_empty ? IDLE : START;
          r_uart_tx <= w_tx_empty;
          if (!w_tx_empty) r_tx_sh <= w_tx_dout;
        end
      endcase
    end
  end
  // RX deserialiser: mid-bit sampling, glitch reject in START, framing error waits for idle line
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_rx_st <= IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh <= '0;
      r_rx_wait <= 1'b0;
    end else begin
      r_rx_cnt <= (r_rx_st == IDLE || w_rx_tick) ? '0 : r_rx_cnt + CW'(1);
      case (r_rx_st)
        IDLE: if (r_rx_wait) r_rx_wait <= ~w_line;
              else if (!w_line) r_rx_st <= START;
        START: if (w_rx_tick) begin
          r_rx_st <= w_line ? IDLE : DATA;
          r_rx_bit <= '0;
        end
        DATA: if (w_rx_tick) begin
          r_rx_sh <= {w_line, r_rx_sh[7:1]};
          r_rx_st <= (r_rx_bit == C_BIT_LAST) ? STOP : DATA;
          r_rx_bit <= r_rx_bit + 3'd1;
        end
        STOP: if (w_rx_tick) begin
          r_rx_st <= IDLE;
          r_rx_wait <= ~w_line;
        end
      endcase
    end
  end
endmodule

// File: doc/odt_console_peer.md
Name: odt_console_peer

Overview:
- Far end of the console ODT character handshake on the FPGA board.
- Transmit path: accepts characters the DCJ11 writes to XBUF (xmt_stb/xmt_rdy pair) and serialises them on uart_tx.
- Receive path: deserialises characters from uart_rx and presents them to the DCJ11 RBUF path (rcv_rdy/rcv_stb pair).
- Each direction is decoupled by an 8-entry FIFO.
- Runs on the 18 MHz board clock; all handshake inputs are asynchronous to it.

Parameters:
- CLK_HZ, 18000000, core clock frequency in Hz.
- BAUD, 115200, UART bit rate; divisor DIV = CLK_HZ/BAUD, truncated (156 at defaults).
- FIFO_DEPTH, 8, entries per FIFO; must be a power of two, minimum 2.

Ports:
- clk  input  1  core clock, rising edge.
- rstb  input  1  reset, synchronous, active-low.
- xmt_stb  input  1  character-written strobe from the bus side; async, high while xmt_data is valid.
- xmt_data  input  8  character from XBUF; stable while xmt_stb is high.
- xmt_rdy  output  1  peer can accept a character; drives the bus side's read-ready.
- rcv_rdy  output  1  character available; drives the bus side's write-ready.
- rcv_data  output  8  head-of-RX-FIFO character.
- rcv_stb  input  1  character-consumed strobe from the bus side (RBUF read); async.
- uart_tx  output  1  serial out, 8N1, idle high.
- uart_rx  input  1  serial in, 8N1, async.
- rx_overrun  output  1  sticky: a received byte was dropped because the RX FIFO was full.

Behaviour:
- Reset values (rstb low at a clk edge):
  - xmt_rdy = 0, rcv_rdy = 0, rcv_data = 0, uart_tx = 1, rx_overrun = 0.
  - Both FIFOs empty, both UART FSMs in IDLE.
  - xmt_rdy rises on the first cycle after reset release (FIFO not full, synced xmt_stb low).
- Synchronisers: xmt_stb, rcv_stb and uart_rx each pass through 2 flops (uart_rx resets to 1, strobes reset to 0). Edge detect uses a third flop.
- TX handshake, 4-phase:
  - Synced rising edge of xmt_stb: push xmt_data into the TX FIFO and force xmt_rdy = 0 on the next cycle.
  - xmt_rdy returns to 1 only when synced xmt_stb = 0 and the TX FIFO is not full.
  - A rising edge while the FIFO is full drops the character. This cannot occur if the bus side honours xmt_rdy.
- RX handshake, 4-phase:
  - rcv_rdy = 1 iff RX FIFO non-empty and synced rcv_stb = 0 and not in pop-hold.
  - rcv_data is the FIFO head, registered and valid whenever rcv_rdy = 1.
  - Synced rising edge of rcv_stb while the FIFO is non-empty: pop one entry, rcv_rdy = 0 next cycle, enter pop-hold.
  - Pop-hold clears when synced rcv_stb = 0.
  - Rising edge of rcv_stb with an empty FIFO: ignored.
  - rcv_stb held high for any length causes exactly one pop.
- UART TX FSM:
  - States IDLE, START, DATA, STOP.
  - IDLE -> START when the TX FIFO is non-empty; pop the byte on that transition.
  - Each state holds for DIV clocks.
  - DATA shifts LSB first, 8 bits, with a 3-bit counter.
  - STOP -> IDLE, or directly -> START if the FIFO is non-empty. Back-to-back frames have no idle gap.
- UART RX FSM:
  - States IDLE, START, DATA, STOP.
  - IDLE -> START on synced uart_rx = 0.
  - In START, sample at DIV/2. If the line is high, treat it as a glitch and return to IDLE.
  - DATA samples every DIV clocks at mid-bit, LSB first.
  - STOP samples at mid-bit.
    - If high, push the byte; if the FIFO is full, drop the byte and set rx_overrun.
    - If low, it is a framing error: discard the byte, wait for the line high, then go to IDLE.
- FIFO full/empty:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap-around by natural overflow.
  - Simultaneous push and pop when full is legal: the pop is served and the push succeeds.
  - Simultaneous push and pop when empty: only the push takes effect.
- Reset mid-frame:
  - uart_tx goes to 1 immediately at the reset edge, and the partial frame is lost.
  - The RX FSM abandons the frame. FIFO contents are discarded.
- Latency:
  - xmt_stb pin rising to xmt_rdy low: 4 clocks.
  - TX FIFO push to uart_tx start bit: 2 clocks when idle.
  - RX stop-bit sample to rcv_rdy high: 2 clocks.

Decomposition:
- Package odt_pkg holds:
  - Functions/constants for DIV and the half-bit count.
  - Enum uart_state_t {IDLE, START, DATA, STOP}, shared by both FSMs.
  - Constant UART_BITS = 8.
- Sub-module sync_fifo (params WIDTH, DEPTH; push, pop, din, dout, full, empty), instantiated twice.
- The UART FSMs stay inline in odt_console_peer.

Test Plan:
- Reset, then pulse xmt_stb (40 clk) with xmt_data = 8'h41:
  - xmt_rdy falls within 4 clk and rises after xmt_stb falls.
  - uart_tx shows frame 0,1,0,0,0,0,0,1,0,1, each bit 156 clk.
- Write 9 characters back-to-back, each waiting for xmt_rdy:
  - xmt_rdy stays low when 8 are queued and the UART is busy.
  - All 9 bytes appear on uart_tx with no gap between frames.
- Drive 8N1 frame 8'h0D on uart_rx:
  - rcv_rdy = 1 with rcv_data = 8'h0D.
  - Raise rcv_stb for 500 clk: one pop, rcv_rdy = 0; lower rcv_stb: rcv_rdy stays 0.
- Send 9 RX frames without any rcv_stb:
  - rx_overrun = 1.
  - Draining yields exactly the first 8 bytes, in order.
- Send a 1/4-bit low glitch, then a frame with stop bit = 0:
  - No push for either.
  - A following valid frame 8'h55 is received correctly.
- Assert rstb low in the middle of a TX data bit:
  - uart_tx = 1 and xmt_rdy = 0 at the next edge.
  - After release, xmt_rdy = 1 within 1 clk and no residual frame is sent.
